// File: rtl/de_regfile_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file and RAW scoreboard.
// Holds the default widths and the per-register counter operation encoding.
package de_regfile_scoreboard_pkg;

   localparam int unsigned DBITS_DEF     = 32;
   localparam int unsigned REGNOBITS_DEF = 5;
   localparam int unsigned REGWORDS_DEF  = 32;
   localparam int unsigned CNTBITS_DEF   = 2;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC
   } cnt_op_t;

   // An issue and a retire to the same register in one cycle cancel out.
   function automatic cnt_op_t cnt_op(input logic inc, input logic dec);
      if (inc && !dec) return CNT_INC;
      if (dec && !inc) return CNT_DEC;
      return CNT_HOLD;
   endfunction

endpackage

// File: rtl/de_regfile_scoreboard_sb_counter_bank.sv
// Per-register in-flight write counters with saturation and a sticky error.
// eff_busy discounts a write retiring this cycle so the WB bypass covers it.
module sb_counter_bank
   import de_regfile_scoreboard_pkg::*;
#(
   parameter int unsigned REGNOBITS = REGNOBITS_DEF,
   parameter int unsigned REGWORDS  = REGWORDS_DEF,
   parameter int unsigned CNTBITS   = CNTBITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc_en,
   input  logic [REGNOBITS-1:0] inc_no,
   input  logic                 dec_en,
   input  logic [REGNOBITS-1:0] dec_no,
   output logic [REGWORDS-1:0]  eff_busy,
   output logic                 error
);

   localparam logic [CNTBITS-1:0] CNT_MAX = '1;

   logic [CNTBITS-1:0]  cnt [REGWORDS];
   logic [REGWORDS-1:0] inc_hit;
   logic [REGWORDS-1:0] dec_hit;

   // Entry 0 is x0: never hit, never busy.
   always_comb begin
      inc_hit  = '0;
      dec_hit  = '0;
      eff_busy = '0;
      for (int unsigned r = 1; r < REGWORDS; r++) begin
         inc_hit[r]  = inc_en && (inc_no == REGNOBITS'(r));
         dec_hit[r]  = dec_en && (dec_no == REGNOBITS'(r));
         eff_busy[r] = cnt[r] > CNTBITS'(dec_hit[r]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < REGWORDS; r++) cnt[r] <= '0;
         error <= 1'b0;
      end else begin
         for (int unsigned r = 1; r < REGWORDS; r++) begin
            case (cnt_op(inc_hit[r], dec_hit[r]))
               CNT_INC: begin
                  if (cnt[r] == CNT_MAX) error <= 1'b1;
                  else                   cnt[r] <= cnt[r] + 1'b1;
               end
               CNT_DEC: begin
                  if (cnt[r] == '0) error <= 1'b1;
                  else              cnt[r] <= cnt[r] - 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/de_regfile_scoreboard.sv
// Decode-stage GPR file with WB commit, same-cycle WB bypass on both reads,
// and a RAW-hazard stall driven by the in-flight write scoreboard.
module de_regfile_scoreboard
   import de_regfile_scoreboard_pkg::*;
#(
   parameter int unsigned DBITS     = DBITS_DEF,
   parameter int unsigned REGNOBITS = REGNOBITS_DEF,
   parameter int unsigned REGWORDS  = REGWORDS_DEF,
   parameter int unsigned CNTBITS   = CNTBITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_wr_reg,
   input  logic [REGNOBITS-1:0] wb_wregno,
   input  logic [DBITS-1:0]     wb_regval,
   input  logic [REGNOBITS-1:0] rs1_no,
   input  logic [REGNOBITS-1:0] rs2_no,
   input  logic                 rs1_used,
   input  logic                 rs2_used,
   input  logic                 issue_valid,
   input  logic                 issue_wr_reg,
   input  logic [REGNOBITS-1:0] issue_rd,
   output logic [DBITS-1:0]     rs1_data,
   output logic [DBITS-1:0]     rs2_data,
   output logic                 stall_DE,
   output logic                 sb_error
);

   logic [DBITS-1:0]    gpr [REGWORDS];
   logic [REGWORDS-1:0] eff_busy;

   sb_counter_bank #(
      .REGNOBITS (REGNOBITS),
      .REGWORDS  (REGWORDS),
      .CNTBITS   (CNTBITS)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .inc_en   (issue_valid && issue_wr_reg),
      .inc_no   (issue_rd),
      .dec_en   (wb_wr_reg),
      .dec_no   (wb_wregno),
      .eff_busy (eff_busy),
      .error    (sb_error)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < REGWORDS; r++) gpr[r] <= '0;
      end else if (wb_wr_reg && (wb_wregno != '0)) begin
         gpr[wb_wregno] <= wb_regval;
      end
   end

   always_comb begin
      rs1_data = gpr[rs1_no];
      rs2_data = gpr[rs2_no];
      if (wb_wr_reg && (wb_wregno == rs1_no)) rs1_data = wb_regval;
      if (wb_wr_reg && (wb_wregno == rs2_no)) rs2_data = wb_regval;
      if (rs1_no == '0) rs1_data = '0;
      if (rs2_no == '0) rs2_data = '0;
   end

   assign stall_DE = (rs1_used && eff_busy[rs1_no]) || (rs2_used && eff_busy[rs2_no]);

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Directed and randomized checks of de_regfile_scoreboard against a
// behavioural model of the register file and in-flight write counts.
module tb_de_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_wr_reg;
   logic [4:0]  wb_wregno;
   logic [31:0] wb_regval;
   logic [4:0]  rs1_no, rs2_no;
   logic        rs1_used, rs2_used;
   logic        issue_valid, issue_wr_reg;
   logic [4:0]  issue_rd;
   logic [31:0] rs1_data, rs2_data;
   logic        stall_DE, sb_error;

   int checks   = 0;
   int failures = 0;

   int          m_cnt [32];
   logic [31:0] m_gpr [32];
   bit          m_err;
   int          q [$];

   de_regfile_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .wb_wr_reg    (wb_wr_reg),
      .wb_wregno    (wb_wregno),
      .wb_regval    (wb_regval),
      .rs1_no       (rs1_no),
      .rs2_no       (rs2_no),
      .rs1_used     (rs1_used),
      .rs2_used     (rs2_used),
      .issue_valid  (issue_valid),
      .issue_wr_reg (issue_wr_reg),
      .issue_rd     (issue_rd),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .stall_DE     (stall_DE),
      .sb_error     (sb_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input int r);
      if (r == 0) return 32'h0;
      if (wb_wr_reg && (int'(wb_wregno) == r)) return wb_regval;
      return m_gpr[r];
   endfunction

   function automatic bit m_busy(input int r, input bit wb, input int wno);
      int pending;
      if (r == 0) return 1'b0;
      pending = m_cnt[r] - ((wb && wno == r) ? 1 : 0);
      return pending > 0;
   endfunction

   task automatic drive(input bit wb, input int wno, input logic [31:0] wval,
                        input int r1, input int r2, input bit u1, input bit u2,
                        input bit iv, input bit iw, input int ird);
      bit exp_stall;
      reset        = 1'b0;
      wb_wr_reg    = wb;
      wb_wregno    = 5'(wno);
      wb_regval    = wval;
      rs1_no       = 5'(r1);
      rs2_no       = 5'(r2);
      rs1_used     = u1;
      rs2_used     = u2;
      issue_valid  = iv;
      issue_wr_reg = iw;
      issue_rd     = 5'(ird);
      #1;
      exp_stall = (u1 && m_busy(r1, wb, wno)) || (u2 && m_busy(r2, wb, wno));
      chk("model_rs1_data", rs1_data, m_read(r1));
      chk("model_rs2_data", rs2_data, m_read(r2));
      chk("model_stall",    32'(stall_DE), 32'(exp_stall));
      chk("model_sb_error", 32'(sb_error), 32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int r = 0; r < 32; r++) begin
            m_cnt[r] = 0;
            m_gpr[r] = 32'h0;
         end
         m_err = 1'b0;
      end else begin
         if (wb_wr_reg && wb_wregno != 5'd0) m_gpr[wb_wregno] = wb_regval;
         for (int r = 1; r < 32; r++) begin
            bit inc;
            bit dec;
            inc = issue_valid && issue_wr_reg && (int'(issue_rd) == r);
            dec = wb_wr_reg && (int'(wb_wregno) == r);
            if (inc && !dec) begin
               if (m_cnt[r] == 3) m_err = 1'b1;
               else               m_cnt[r]++;
            end else if (dec && !inc) begin
               if (m_cnt[r] == 0) m_err = 1'b1;
               else               m_cnt[r]--;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      wb_wr_reg    = 1'b1;
      wb_wregno    = 5'($urandom_range(1, 31));
      wb_regval    = $urandom;
      issue_valid  = 1'b1;
      issue_wr_reg = 1'b1;
      issue_rd     = 5'($urandom_range(1, 31));
      rs1_no       = 5'd0;
      rs2_no       = 5'd0;
      rs1_used     = 1'b0;
      rs2_used     = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      bit wb, u1, u2, iv, iw, st;
      int wno, r1, r2, ird;
      logic [31:0] wval;

      @(negedge clk);
      do_reset();

      // Reset state
      drive(0, 0, 0, 5, 0, 1, 1, 0, 0, 0);
      chk("rst_rs1", rs1_data, 32'h0);
      chk("rst_rs2", rs2_data, 32'h0);
      chk("rst_stall", 32'(stall_DE), 32'h0);
      chk("rst_err", 32'(sb_error), 32'h0);
      tick();

      // Issue x7, two stalled cycles, then WB bypass and committed read
      drive(0, 0, 0, 7, 0, 0, 0, 1, 1, 7);
      tick();
      drive(0, 0, 0, 7, 0, 1, 0, 0, 0, 0);
      chk("raw_stall_a", 32'(stall_DE), 32'h1);
      tick();
      drive(0, 0, 0, 7, 0, 1, 0, 0, 0, 0);
      chk("raw_stall_b", 32'(stall_DE), 32'h1);
      tick();
      drive(1, 7, 32'hDEADBEEF, 7, 0, 1, 0, 0, 0, 0);
      chk("wb_bypass_stall", 32'(stall_DE), 32'h0);
      chk("wb_bypass_data", rs1_data, 32'hDEADBEEF);
      tick();
      drive(0, 0, 0, 7, 0, 1, 0, 0, 0, 0);
      chk("gpr_read_x7", rs1_data, 32'hDEADBEEF);
      tick();

      // Two producers of x3
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
      tick();
      drive(1, 3, 32'h11, 3, 0, 1, 0, 0, 0, 0);
      chk("x3_still_stall", 32'(stall_DE), 32'h1);
      tick();
      drive(1, 3, 32'h22, 3, 0, 1, 0, 0, 0, 0);
      chk("x3_clear", 32'(stall_DE), 32'h0);
      chk("x3_data", rs1_data, 32'h22);
      tick();

      // x0 is never written and never busy
      drive(1, 0, 32'h1234, 0, 0, 1, 1, 1, 1, 0);
      chk("x0_bypass_zero", rs1_data, 32'h0);
      chk("x0_no_stall", 32'(stall_DE), 32'h0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      chk("x0_read_zero", rs1_data, 32'h0);
      chk("x0_err", 32'(sb_error), 32'h0);
      tick();

      // Same-cycle issue and WB of x9 at count 1
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
      tick();
      drive(1, 9, 32'h99, 0, 9, 0, 0, 1, 1, 9);
      tick();
      drive(0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
      chk("x9_stall", 32'(stall_DE), 32'h1);
      tick();
      drive(1, 9, 32'hAA, 0, 9, 0, 1, 0, 0, 0);
      chk("x9_clear", 32'(stall_DE), 32'h0);
      chk("x9_data", rs2_data, 32'hAA);
      tick();

      // Underflow: WB x4 with nothing in flight
      drive(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 4, 0, 1, 0, 0, 0, 0);
      chk("uflow_err", 32'(sb_error), 32'h1);
      chk("uflow_data", rs1_data, 32'h44);
      chk("uflow_stall", 32'(stall_DE), 32'h0);
      tick();

      // Overflow: four producers of x6, counter saturates at 3
      do_reset();
      drive(0, 0, 0, 4, 0, 1, 0, 0, 0, 0);
      chk("rst_clr_err", 32'(sb_error), 32'h0);
      chk("rst_clr_x4", rs1_data, 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 6);
         tick();
      end
      drive(0, 0, 0, 6, 0, 1, 0, 0, 0, 0);
      chk("oflow_err", 32'(sb_error), 32'h1);
      chk("oflow_stall", 32'(stall_DE), 32'h1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1, 6, 32'h60 + 32'(i), 6, 0, 1, 0, 0, 0, 0);
         chk("sat_stall", 32'(stall_DE), 32'h1);
         tick();
      end
      drive(1, 6, 32'h66, 6, 0, 1, 0, 0, 0, 0);
      chk("sat_drain", 32'(stall_DE), 32'h0);
      tick();

      // Reset mid-sequence with a producer outstanding
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 6);
      tick();
      do_reset();
      drive(0, 0, 0, 6, 3, 1, 1, 0, 0, 0);
      chk("mid_rst_x6", rs1_data, 32'h0);
      chk("mid_rst_stall", 32'(stall_DE), 32'h0);
      chk("mid_rst_err", 32'(sb_error), 32'h0);
      tick();

      // Randomized protocol-legal traffic
      q.delete();
      for (int n = 0; n < 400; n++) begin
         wb   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         wno  = wb ? q.pop_front() : int'($urandom_range(0, 31));
         wval = $urandom;
         r1   = $urandom_range(0, 7);
         r2   = $urandom_range(0, 7);
         u1   = $urandom_range(0, 1);
         u2   = $urandom_range(0, 1);
         st   = (u1 && m_busy(r1, wb, wno)) || (u2 && m_busy(r2, wb, wno));
         iw   = $urandom_range(0, 3) != 0;
         ird  = $urandom_range(0, 7);
         iv   = !st && (q.size() < 3) && ($urandom_range(0, 2) != 0);
         if (iv && iw) q.push_back(ird);
         drive(wb, wno, wval, r1, r2, u1, u2, iv, iw, ird);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rand_no_err", 32'(sb_error), 32'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/de_regfile_scoreboard.md
Name: de_regfile_scoreboard

Overview:
- Receiving end of the WB→DE register-write path; instantiated inside the decode stage.
- Holds the 32-entry GPR file and commits WB writes to it.
- Serves two combinational source reads with same-cycle WB bypass.
- Tracks in-flight destination writes per register and raises a decode stall on RAW hazards. CSR writes are out of scope; the wr_csr/wcsrno fields are not connected here.

Parameters:
- DBITS, 32, data width
- REGNOBITS, 5, register index width
- REGWORDS, 32, number of GPRs
- CNTBITS, 2, per-register in-flight counter width; max 3 in flight (AGEX, MEM, WB)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high
- wb_wr_reg  input  1  WB instruction writes a GPR this cycle
- wb_wregno  input  REGNOBITS  WB destination register
- wb_regval  input  DBITS  WB write data
- rs1_no  input  REGNOBITS  decode source 1 index
- rs2_no  input  REGNOBITS  decode source 2 index
- rs1_used  input  1  instruction in DE reads rs1
- rs2_used  input  1  instruction in DE reads rs2
- issue_valid  input  1  DE instruction leaves DE this cycle (not stalled, not squashed)
- issue_wr_reg  input  1  issuing instruction writes a GPR
- issue_rd  input  REGNOBITS  issuing instruction destination
- rs1_data  output  DBITS  source 1 value
- rs2_data  output  DBITS  source 2 value
- stall_DE  output  1  RAW hazard; DE must hold
- sb_error  output  1  sticky protocol-violation flag

Behaviour:
- Reset (synchronous): all 32 GPRs ← 0, all counters ← 0, sb_error ← 0. WB or issue events in the reset cycle are discarded.
- Register x0:
  - Writes are ignored; reads return 0.
  - Its counter is never incremented; issue_rd=0 is a no-op.
- Write commit: at posedge, if wb_wr_reg and wb_wregno≠0, then GPR[wb_wregno] ← wb_regval.
- Reads are combinational, zero latency:
  - rsN_data = 0 if rsN_no=0.
  - Else wb_regval if wb_wr_reg and wb_wregno=rsN_no (bypass).
  - Else GPR[rsN_no].
- Counters, updated at posedge, per register r≠0:
  - inc = issue_valid & issue_wr_reg & issue_rd=r
  - dec = wb_wr_reg & wb_wregno=r
  - inc&dec: count unchanged. inc only: +1. dec only: −1.
- Effective busy: eff(r) = count(r) − dec(r), so a write retiring this cycle is visible via the bypass.
- stall_DE = (rs1_used & eff(rs1_no)>0) | (rs2_used & eff(rs2_no)>0). Combinational; depends on the current-cycle WB.
- Decode must not assert issue_valid while stall_DE=1. The block does not gate issue itself.
- Error conditions; sb_error sets and stays set until reset:
  - Overflow: inc & !dec & count=3. Counter saturates at 3.
  - Underflow: dec & !inc & count=0. Counter stays 0; the GPR write still commits.
- Flush: squashed DE/FE instructions never assert issue_valid, so there is no flush port. Instructions already past DE always reach WB.
- Issue and WB to the same register in the same cycle with count=1: count stays 1. The new producer is outstanding, so a consumer still stalls next cycle.

Decomposition:
- Shared package / VX_define.vh additions:
  - CNTBITS
  - Field-slice macros for the from_WB_to_DE bus (wr_reg, wregno, regval offsets), so DE_STAGE unpacks consistently with WB_STAGE.
- One natural sub-module: sb_counter_bank. Holds 32 counters with inc/dec/saturation logic and an eff-busy vector output. The GPR array and bypass muxes stay in the top.

Test Plan:
- Reset, then read rs1=5, rs2=0 → both data 0, stall_DE=0, sb_error=0.
- Issue rd=7, then 3 cycles later WB x7=0xDEADBEEF while rs1_no=7 and rs1_used=1:
  - stall_DE=1 on the two intermediate cycles.
  - WB cycle: stall_DE=0 and rs1_data=0xDEADBEEF (bypass).
  - Next cycle: GPR read returns 0xDEADBEEF.
- Issue rd=3 twice back-to-back (count=2), WB x3=0x11 once → rs1_no=3 still stalls. Second WB x3=0x22 → stall clears and rs1_data=0x22.
- WB x0=0x1234 with wb_wr_reg=1, and issue rd=0 → x0 reads 0, never stalls, sb_error=0.
- Same-cycle issue rd=9 and WB x9 at count=1 → count stays 1; next cycle rs2_no=9 with rs2_used=1 stalls.
- Error paths:
  - WB x4 with count=0 → sb_error=1, x4 updated.
  - Four issues to rd=6 with no WB → sb_error=1, counter 3.
  - Assert reset mid-sequence → all cleared next cycle.
